multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 2, width of ALUControl; legal values 2 or 3.
REQ-002 SHALL have parameter FLAG_RESET, default 4'b0000, reset value of the flag register {N,Z,C,V}.
REQ-003 SHALL run on one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-004 Ports SHALL be exactly:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cond  in  4  instruction condition field
- op  in  2  instruction class
- funct  in  6  I-bit, opcode[3:0], S/L bit
- rd  in  4  destination register
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- MemReady  in  1  memory access done this cycle
- PCWrite  out  1  PC load strobe
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0 = PC, 1 = ALU result
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALUOut, 01 = mem data, 10 = ALU direct
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 = Rm, 01 = extended imm, 10 = constant 4
- ImmSrc  out  2  00 = imm8, 01 = imm12, 10 = imm24
- RegSrc  out  2  register-address selects
- ALUControl  out  ALU_CTRL_W  ALU operation
- Flags  out  4  registered {N,Z,C,V}
- State  out  4  current FSM state code, for debug

Function
REQ-005 SHALL implement a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH.
REQ-006 In FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; IRWrite and PCWrite SHALL be 1 only in a cycle with MemReady=1, which SHALL also advance to DECODE; otherwise stay in FETCH.
REQ-007 DECODE SHALL be a single cycle; cond fails -> FETCH with no strobes; else op=01 -> MEMADR, op=00 with funct[5]=0 -> EXECR, op=00 with funct[5]=1 -> EXECI, op=10 -> BRANCH, op=11 -> FETCH.
REQ-008 MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD; then funct[0]=1 -> MEMRD, funct[0]=0 -> MEMWR (RegSrc=10 for stores).
REQ-009 MEMRD: AdrSrc=1; hold until MemReady=1, then MEMWB; MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-010 MEMWR: AdrSrc=1, MemWrite=1 held every cycle until MemReady=1, then FETCH.
REQ-011 EXECR: ALUSrcA=0, ALUSrcB=00. EXECI: ALUSrcA=0, ALUSrcB=01, ImmSrc=00. Both -> ALUWB after one cycle.
REQ-012 ALU decode from funct[4:1]: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 1010 CMP=SUB; with ALU_CTRL_W=3 also 0001 EOR=4, 1101 MOV=5; any other opcode gives ALUControl=0 with RegWrite suppressed.
REQ-013 Flags SHALL load ALUFlags at the clock edge ending EXECR/EXECI when funct[0]=1 or the opcode is CMP; otherwise Flags hold.
REQ-014 ALUWB: ResultSrc=00; RegWrite=1 unless CMP or unsupported; if rd=15, PCWrite=1 replaces RegWrite; then FETCH.
REQ-015 BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ResultSrc=10, RegSrc=01, PCWrite=1; then FETCH.
REQ-016 Condition check SHALL use registered Flags and all ARM codes EQ..AL (0000-1110); cond=1111 SHALL fail.
REQ-017 Any output not listed for a state SHALL be 0.

Reset
REQ-018 rst_n low SHALL asynchronously force State=FETCH and Flags=FLAG_RESET, and force PCWrite, IRWrite, MemWrite and RegWrite to 0 regardless of MemReady.
REQ-019 Reset asserted mid-access (MEMRD or MEMWR) SHALL abandon the access; the first post-reset cycle is FETCH.

Configuration
REQ-020 Macro COND_EXEC_EN defined: condition check per REQ-016. Macro undefined: cond is ignored and every instruction executes as AL; Flags still update per REQ-013.

Verification
REQ-021 ADD register form (op=00, funct=001000, cond=1110), MemReady=1 -> state sequence 0,1,6,8,0; RegWrite=1 only in state 8; ALUControl=0.
REQ-022 LDR (op=01, funct[0]=1) with MemReady low for 3 cycles in MEMRD -> stays in state 3 for 4 cycles, then state 4 with RegWrite=1 and ResultSrc=01.
REQ-023 CMP (funct=010101) with ALUFlags=0100, then BEQ (op=10, cond=0000) -> Flags=0100; BRANCH taken with PCWrite=1; with Z=0, DECODE returns to FETCH with no strobes.
REQ-024 ORR with rd=15 -> ALUWB gives PCWrite=1 and RegWrite=0.
REQ-025 rst_n pulsed low during MEMWR with MemReady=0 -> MemWrite drops to 0 immediately; State=0 and Flags=0000 after release.
REQ-026 COND_EXEC_EN undefined, cond=0000, Z=0 -> instruction executes fully (sequence 0,1,6,8,0).

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: fetch/decode/memory/ALU/branch FSM with flag register.
// Define COND_EXEC_EN to enable condition-code checking; otherwise every instruction executes as AL.
module multicycle_control_unit #(
  parameter int         ALU_CTRL_W = 2,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            ALUFlags,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            Flags,
  output logic [3:0]            State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t                r_state;
  logic [3:0]            r_flags;
  logic                  w_cond_ok;
  logic                  w_alu_ok;
  logic                  w_cmp;
  logic                  w_set_flags;
  logic                  w_wb;
  logic [ALU_CTRL_W-1:0] w_alu;
  logic                  w_pcw;
  logic                  w_irw;
  logic                  w_mw;
  logic                  w_rw;

`ifdef COND_EXEC_EN
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ok = 1'b0;
    unique case (cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = !w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = !w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = !w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = !w_v;
      4'b1000: w_cond_ok = w_c && !w_z;
      4'b1001: w_cond_ok = !w_c || w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = !w_z && (w_n == w_v);
      4'b1101: w_cond_ok = w_z || (w_n != w_v);
      4'b1110: w_cond_ok = 1'b1;
      4'b1111: w_cond_ok = 1'b0;
    endcase
  end
`else
  logic w_unused_cond;
  assign w_unused_cond = ^cond;
  assign w_cond_ok     = 1'b1;
`endif

  // EOR/MOV only exist when ALUControl is wide enough to encode them
  always_comb begin
    w_alu_ok = 1'b1;
    w_alu    = '0;
    case (funct[4:1])
      4'b0100: w_alu = ALU_CTRL_W'(3'd0);
      4'b0010: w_alu = ALU_CTRL_W'(3'd1);
      4'b1010: w_alu = ALU_CTRL_W'(3'd1);
      4'b0000: w_alu = ALU_CTRL_W'(3'd2);
      4'b1100: w_alu = ALU_CTRL_W'(3'd3);
      4'b0001: begin
        if (ALU_CTRL_W >= 3) w_alu = ALU_CTRL_W'(3'd4);
        else                 w_alu_ok = 1'b0;
      end
      4'b1101: begin
        if (ALU_CTRL_W >= 3) w_alu = ALU_CTRL_W'(3'd5);
        else                 w_alu_ok = 1'b0;
      end
      default: w_alu_ok = 1'b0;
    endcase
  end

  assign w_cmp       = (funct[4:1] == 4'b1010);
  assign w_set_flags = funct[0] | w_cmp;
  assign w_wb        = w_alu_ok & ~w_cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_flags <= FLAG_RESET;
    end else begin
      case (r_state)
        FETCH:  if (MemReady) r_state <= DECODE;
        DECODE: begin
          if (!w_cond_ok) r_state <= FETCH;
          else begin
            unique case (op)
              2'b00: r_state <= funct[5] ? EXECI : EXECR;
              2'b01: r_state <= MEMADR;
              2'b10: r_state <= BRANCH;
              2'b11: r_state <= FETCH;
            endcase
          end
        end
        MEMADR: r_state <= funct[0] ? MEMRD : MEMWR;
        MEMRD:  if (MemReady) r_state <= MEMWB;
        MEMWB:  r_state <= FETCH;
        MEMWR:  if (MemReady) r_state <= FETCH;
        EXECR, EXECI: begin
          r_state <= ALUWB;
          if (w_set_flags) r_flags <= ALUFlags;
        end
        ALUWB:   r_state <= FETCH;
        BRANCH:  r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_mw       = 1'b0;
    w_rw       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = '0;
    case (r_state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = MemReady;
        w_pcw     = MemReady;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        RegSrc  = funct[0] ? 2'b00 : 2'b10;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        w_mw   = 1'b1;
      end
      EXECR: ALUControl = w_alu;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = w_alu;
      end
      ALUWB: begin
        w_rw  = w_wb && (rd != 4'd15);
        w_pcw = w_wb && (rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        RegSrc    = 2'b01;
        w_pcw     = 1'b1;
      end
      default: ;
    endcase
  end

  // strobes must vanish the instant reset asserts, even mid-access
  assign PCWrite  = w_pcw & rst_n;
  assign IRWrite  = w_irw & rst_n;
  assign MemWrite = w_mw & rst_n;
  assign RegWrite = w_rw & rst_n;
  assign Flags    = r_flags;
  assign State    = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction-level bench for multicycle_control_unit.
// Expected per-cycle behaviour is expanded from each whole instruction.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int         ALU_W = 2;
  localparam logic [3:0] FRST  = 4'b0000;
`ifdef COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       cond = '0;
  logic [1:0]       op = '0;
  logic [5:0]       funct = '0;
  logic [3:0]       rd = '0;
  logic [3:0]       ALUFlags = '0;
  logic             MemReady = 1'b1;
  logic             PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite;
  logic [1:0]       ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic             ALUSrcA;
  logic [ALU_W-1:0] ALUControl;
  logic [3:0]       Flags, State;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALU_CTRL_W(ALU_W), .FLAG_RESET(FRST)) dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct),
    .rd(rd), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags), .State(State)
  );

  typedef struct packed {
    logic       mr;
    logic [3:0] st;
    logic       pcw, irw, adr, mw, rw;
    logic [1:0] res;
    logic       asa;
    logic [1:0] asb, imm, rsrc;
    logic [2:0] alu;
    logic [3:0] flg;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        exp_c;
  logic        exp_v = 1'b0;
  logic [19:0] pend;
  logic [3:0]  mflags = FRST;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_v) begin
      check("State", 32'(State), 32'(exp_c.st));
      check("strobes", 32'({PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite}),
            32'({exp_c.pcw, exp_c.irw, exp_c.adr, exp_c.mw, exp_c.rw}));
      check("muxes", 32'({ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc}),
            32'({exp_c.res, exp_c.asa, exp_c.asb, exp_c.imm, exp_c.rsrc}));
      check("ALUControl", 32'(ALUControl), 32'(exp_c.alu[ALU_W-1:0]));
      check("Flags", 32'(Flags), 32'(exp_c.flg));
    end
  end

  function automatic logic rnd();
    return logic'($urandom_range(1, 0));
  endfunction

  function automatic cyc_t blank(input logic mr, input logic [3:0] st);
    cyc_t e;
    e     = '0;
    e.mr  = mr;
    e.st  = st;
    e.flg = mflags;
    return e;
  endfunction

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, p;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    p = z;
      4'd1:    p = !z;
      4'd2:    p = cy;
      4'd3:    p = !cy;
      4'd4:    p = n;
      4'd5:    p = !n;
      4'd6:    p = v;
      4'd7:    p = !v;
      4'd8:    p = cy && !z;
      4'd9:    p = !cy || z;
      4'd10:   p = (n == v);
      4'd11:   p = (n != v);
      4'd12:   p = !z && (n == v);
      4'd13:   p = z || (n != v);
      4'd14:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return !COND_EN || p;
  endfunction

  // returns {supported, ALU code}
  function automatic logic [3:0] alu_of(input logic [3:0] opc);
    if (opc == 4'b0100) return {1'b1, 3'd0};
    if (opc == 4'b0010) return {1'b1, 3'd1};
    if (opc == 4'b1010) return {1'b1, 3'd1};
    if (opc == 4'b0000) return {1'b1, 3'd2};
    if (opc == 4'b1100) return {1'b1, 3'd3};
    if (ALU_W == 3 && opc == 4'b0001) return {1'b1, 3'd4};
    if (ALU_W == 3 && opc == 4'b1101) return {1'b1, 3'd5};
    return 4'b0000;
  endfunction

  function automatic logic [31:0] seq_of();
    logic [31:0] s;
    s = '0;
    foreach (q[i]) s = (s << 4) | 32'(q[i].st);
    return s;
  endfunction

  task automatic build(input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r,
                       input logic [3:0] af, input int fw, input int mw);
    cyc_t       e;
    logic [3:0] a;
    logic       wb;
    q.delete();
    pend = {c, o, f, r, af};
    for (int i = 0; i <= fw; i++) begin
      e = blank(i == fw, 4'd0);
      e.asa = 1'b1; e.asb = 2'b10; e.res = 2'b10;
      e.pcw = (i == fw); e.irw = (i == fw);
      q.push_back(e);
    end
    q.push_back(blank(rnd(), 4'd1));
    if (!cond_pass(c, mflags) || o == 2'b11) return;
    case (o)
      2'b01: begin
        e = blank(rnd(), 4'd2);
        e.asb = 2'b01; e.imm = 2'b01;
        e.rsrc = f[0] ? 2'b00 : 2'b10;
        q.push_back(e);
        if (f[0]) begin
          for (int i = 0; i <= mw; i++) begin
            e = blank(i == mw, 4'd3); e.adr = 1'b1; q.push_back(e);
          end
          e = blank(rnd(), 4'd4); e.res = 2'b01; e.rw = 1'b1;
          q.push_back(e);
        end else begin
          for (int i = 0; i <= mw; i++) begin
            e = blank(i == mw, 4'd5); e.adr = 1'b1; e.mw = 1'b1;
            q.push_back(e);
          end
        end
      end
      2'b00: begin
        a = alu_of(f[4:1]);
        e = blank(rnd(), f[5] ? 4'd7 : 4'd6);
        e.asb = f[5] ? 2'b01 : 2'b00;
        e.alu = a[2:0];
        q.push_back(e);
        if (f[0] || f[4:1] == 4'b1010) mflags = af;
        wb = a[3] && (f[4:1] != 4'b1010);
        e = blank(rnd(), 4'd8);
        e.rw = wb && (r != 4'd15);
        e.pcw = wb && (r == 4'd15);
        q.push_back(e);
      end
      default: begin
        e = blank(rnd(), 4'd9);
        e.asb = 2'b01; e.imm = 2'b10; e.res = 2'b10;
        e.rsrc = 2'b01; e.pcw = 1'b1;
        q.push_back(e);
      end
    endcase
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) begin
      @(posedge clk); #1;
      {cond, op, funct, rd, ALUFlags} = pend;
      exp_c = q.pop_front();
      MemReady = exp_c.mr;
      exp_v = 1'b1;
      @(negedge clk); #1;
    end
    exp_v = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_State", 32'(State), 32'd0);
    check("rst_PCW_IRW", 32'({PCWrite, IRWrite}), 32'd0);
    check("rst_Flags", 32'(Flags), 32'(FRST));
    #9;
    MemReady = 1'b0;
    rst_n = 1'b1;

    build(4'hE, 2'b00, 6'b001000, 4'd3, 4'd0, 0, 0);
    check("add_seq", seq_of(), 32'h0168);
    check("add_len", 32'(q.size()), 32'd4);
    check("add_rw", 32'({q[0].rw, q[1].rw, q[2].rw, q[3].rw}), 32'b0001);
    play(1000);

    build(4'hE, 2'b01, 6'b000001, 4'd2, 4'd0, 0, 3);
    check("ldr_seq", seq_of(), 32'h01233334);
    check("ldr_wb", 32'({q[7].rw, q[7].res}), 32'b101);
    play(1000);

    build(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 0, 0);
    play(1000);
    check("cmp_flags", 32'(Flags), 32'b0100);

    build(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 1, 0);
    check("beq_seq", seq_of(), 32'h0019);
    check("beq_pcw", 32'(q[3].pcw), 32'd1);
    play(1000);

    build(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0000, 0, 0);
    play(1000);
`ifdef COND_EXEC_EN
    build(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 0, 0);
    check("beq_nt_len", 32'(q.size()), 32'd2);
`else
    build(4'h0, 2'b00, 6'b001000, 4'd1, 4'd0, 0, 0);
    check("al_seq", seq_of(), 32'h0168);
`endif
    play(1000);

    build(4'hE, 2'b00, 6'b011000, 4'd15, 4'd0, 0, 0);
    check("orr_pc", 32'({q[3].pcw, q[3].rw}), 32'b10);
    play(1000);

    build(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1011, 0, 0);
    play(1000);
    build(4'hE, 2'b01, 6'b000000, 4'd4, 4'd0, 0, 6);
    play(5);
    check("str_mw", 32'({State, MemWrite}), 32'({4'd5, 1'b1}));
    MemReady = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    check("rst_mid_State", 32'(State), 32'd0);
    MemReady = 1'b0;
    #9;
    rst_n = 1'b1;
    #1;
    check("post_rst", 32'({State, Flags}), 32'({4'd0, FRST}));
    mflags = FRST;
    q.delete();

    for (int k = 0; k < 200; k++) begin
      build(4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom),
            4'($urandom), int'($urandom_range(2, 0)),
            int'($urandom_range(3, 0)));
      play(1000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
